// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct fields, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        IEXEC,
        IWB,
        BRANCH,
        JUMP
    } state_e;

    // Which family of ALU operation the current state asks for.
    typedef enum logic [2:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT,
        ALUOP_IMM
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic isImmOp(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

    // Logical immediates take a zero-extended operand, arithmetic ones sign-extend.
    function automatic logic isZextOp(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: turns the state's operation class plus the
// instruction's opcode/funct into an ALU control code.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  alu_op_e               alu_op_i,
    input  logic [5:0]            op_i,
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  funct_valid_o
);

    logic [3:0] functCode;
    logic [3:0] immCode;
    logic [3:0] aluCode;

    always_comb begin
        functCode     = ALU_AND;
        funct_valid_o = 1'b1;
        case (funct_i)
            F_ADD:   functCode = ALU_ADD;
            F_SUB:   functCode = ALU_SUB;
            F_AND:   functCode = ALU_AND;
            F_OR:    functCode = ALU_OR;
            F_SLT:   functCode = ALU_SLT;
            F_SLL:   functCode = ALU_SLL;
            F_SRL:   functCode = ALU_SRL;
            F_SRA:   functCode = ALU_SRA;
            default: funct_valid_o = 1'b0;
        endcase
    end

    always_comb begin
        immCode = ALU_ADD;
        case (op_i)
            OP_ANDI: immCode = ALU_AND;
            OP_ORI:  immCode = ALU_OR;
            OP_SLTI: immCode = ALU_SLT;
            default: immCode = ALU_ADD;
        endcase
    end

    always_comb begin
        aluCode = ALU_AND;
        case (alu_op_i)
            ALUOP_ADD:   aluCode = ALU_ADD;
            ALUOP_SUB:   aluCode = ALU_SUB;
            ALUOP_FUNCT: aluCode = functCode;
            ALUOP_IMM:   aluCode = immCode;
            default:     aluCode = ALU_AND;
        endcase
    end

    assign alu_control_o = ALU_CTRL_W'(aluCode);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and counts retired instructions.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            op_i,
    input  logic [5:0]            funct_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  iord_o,
    output logic                  ir_write_o,
    output logic                  pc_write_o,
    output logic [1:0]            pc_src_o,
    output logic                  alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic                  imm_zext_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  reg_dst_o,
    output logic                  mem_to_reg_o,
    output logic                  reg_write_o,
    output logic                  illegal_o,
    output logic [CNT_W-1:0]      instret_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             memReady;
    logic             functValid;
    logic             retire;
    alu_op_e          aluOp;

    assign memReady = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    mc_alu_dec #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_dec (
        .alu_op_i      (aluOp),
        .op_i          (op_i),
        .funct_i       (funct_i),
        .alu_control_o (alu_control_o),
        .funct_valid_o (functValid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    assign instret_o = instret_q;

    // Outputs are gated by rst_ni directly so nothing is enabled while reset is held.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        aluOp        = ALUOP_NONE;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PCSRC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = ALUSRCB_REG;
        imm_zext_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        illegal_o    = 1'b0;

        if (rst_ni) begin
            case (state_q)
                FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = ALUSRCB_FOUR;
                    aluOp       = ALUOP_ADD;
                    ir_write_o  = memReady;
                    pc_write_o  = memReady;
                    if (memReady) state_d = DECODE;
                end
                DECODE: begin
                    alu_src_b_o = ALUSRCB_BRIMM;
                    aluOp       = ALUOP_ADD;
                    case (op_i)
                        OP_LW, OP_SW:                      state_d = MEMADR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
                        OP_BEQ, OP_BNE:                    state_d = BRANCH;
                        OP_J:                              state_d = JUMP;
                        OP_RTYPE: begin
                            if (functValid) begin
                                state_d = EXEC;
                            end else begin
                                illegal_o = 1'b1;
                                state_d   = FETCH;
                            end
                        end
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUSRCB_IMM;
                    aluOp       = ALUOP_ADD;
                    state_d     = (op_i == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    iord_o     = 1'b1;
                    mem_read_o = 1'b1;
                    if (memReady) state_d = MEMWB;
                end
                MEMWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                MEMWR: begin
                    iord_o      = 1'b1;
                    mem_write_o = 1'b1;
                    if (memReady) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
                EXEC: begin
                    alu_src_a_o = 1'b1;
                    aluOp       = ALUOP_FUNCT;
                    state_d     = ALUWB;
                end
                ALUWB: begin
                    reg_dst_o   = 1'b1;
                    reg_write_o = 1'b1;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                IEXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = ALUSRCB_IMM;
                    imm_zext_o  = isImmOp(op_i) && isZextOp(op_i);
                    aluOp       = ALUOP_IMM;
                    state_d     = IWB;
                end
                IWB: begin
                    reg_write_o = 1'b1;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                BRANCH: begin
                    alu_src_a_o = 1'b1;
                    aluOp       = ALUOP_SUB;
                    pc_src_o    = PCSRC_ALUOUT;
                    pc_write_o  = (op_i == OP_BNE) ? ~zero_i : zero_i;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                JUMP: begin
                    pc_src_o   = PCSRC_JUMP;
                    pc_write_o = 1'b1;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the full control vector against hand values.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic [5:0]  op_i;
    logic [5:0]  funct_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        iord_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic        imm_zext_o;
    logic [3:0]  alu_control_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        reg_write_o;
    logic        illegal_o;
    logic [31:0] instret_o;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control_unit #(
        .ALU_CTRL_W(4),
        .MEM_HANDSHAKE(1'b1),
        .CNT_W(32)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .iord_o       (iord_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .imm_zext_o   (imm_zext_o),
        .alu_control_o(alu_control_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .illegal_o    (illegal_o),
        .instret_o    (instret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Vector order: mem_read, mem_write, iord, ir_write, pc_write, pc_src[2], alu_src_a,
    // alu_src_b[2], imm_zext, alu_control[4], reg_dst, mem_to_reg, reg_write, illegal.
    logic [18:0] obsCtrl;
    assign obsCtrl = {mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                      alu_src_a_o, alu_src_b_o, imm_zext_o, alu_control_o,
                      reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o};

    localparam logic [18:0] V_RESET     = 19'd0;
    localparam logic [18:0] V_FETCH     = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_FETCHW    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_DECODE    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_ILLEGAL   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [18:0] V_MEMADR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_MEMRD     = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_MEMWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [18:0] V_MEMWR     = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_EXEC_SUB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_ALUWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [18:0] V_IEXEC_ORI = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_IEXEC_ADD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_IWB       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [18:0] V_BR_TAKEN  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_BR_NOT    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] V_JUMP      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [18:0] expected);
        checkOutput(tag, {13'd0, obsCtrl}, {13'd0, expected});
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input logic zero, input logic ready);
        op_i        = op;
        funct_i     = funct;
        zero_i      = zero;
        mem_ready_i = ready;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Checks a ready FETCH and the following DECODE, leaving the FSM one state past DECODE.
    task automatic fetchDecode(input string tag, input logic [5:0] op, input logic [5:0] funct,
                               input logic [18:0] expDecode);
        applyStimulus(op, funct, 1'b0, 1'b1);
        checkCtrl({tag, ".fetch"}, V_FETCH);
        nextCycle();
        checkCtrl({tag, ".decode"}, expDecode);
        nextCycle();
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        op_i        = OP_LW;
        funct_i     = 6'd0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkCtrl("reset.ctrl", V_RESET);
        checkOutput("reset.instret", instret_o, 32'd0);

        rst_ni = 1'b1;
        fetchDecode("lw", OP_LW, 6'd0, V_DECODE);
        checkCtrl("lw.memadr", V_MEMADR);
        nextCycle();
        checkCtrl("lw.memrd", V_MEMRD);
        nextCycle();
        checkCtrl("lw.memwb", V_MEMWB);
        checkOutput("lw.instret_before", instret_o, 32'd0);
        nextCycle();
        checkOutput("lw.instret_after", instret_o, 32'd1);

        fetchDecode("sw", OP_SW, 6'd0, V_DECODE);
        checkCtrl("sw.memadr", V_MEMADR);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_SW, 6'd0, 1'b0, (i == 3));
            checkCtrl($sformatf("sw.memwr%0d", i), V_MEMWR);
            checkOutput($sformatf("sw.instret_wait%0d", i), instret_o, 32'd1);
            nextCycle();
        end
        checkOutput("sw.instret_after", instret_o, 32'd2);

        fetchDecode("bne0", OP_BNE, 6'd0, V_DECODE);
        applyStimulus(OP_BNE, 6'd0, 1'b0, 1'b1);
        checkCtrl("bne0.branch", V_BR_TAKEN);
        nextCycle();
        checkOutput("bne0.instret", instret_o, 32'd3);

        fetchDecode("bne1", OP_BNE, 6'd0, V_DECODE);
        applyStimulus(OP_BNE, 6'd0, 1'b1, 1'b1);
        checkCtrl("bne1.branch", V_BR_NOT);
        nextCycle();
        checkOutput("bne1.instret", instret_o, 32'd4);

        fetchDecode("beq1", OP_BEQ, 6'd0, V_DECODE);
        applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
        checkCtrl("beq1.branch", V_BR_TAKEN);
        nextCycle();
        fetchDecode("beq0", OP_BEQ, 6'd0, V_DECODE);
        applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b1);
        checkCtrl("beq0.branch", V_BR_NOT);
        nextCycle();
        checkOutput("beq.instret", instret_o, 32'd6);

        fetchDecode("ori", OP_ORI, 6'd0, V_DECODE);
        checkCtrl("ori.iexec", V_IEXEC_ORI);
        nextCycle();
        checkCtrl("ori.iwb", V_IWB);
        nextCycle();
        checkOutput("ori.instret", instret_o, 32'd7);

        fetchDecode("addi", OP_ADDI, 6'd0, V_DECODE);
        checkCtrl("addi.iexec", V_IEXEC_ADD);
        nextCycle();
        checkCtrl("addi.iwb", V_IWB);
        nextCycle();
        checkOutput("addi.instret", instret_o, 32'd8);

        applyStimulus(OP_RTYPE, F_SUB, 1'b0, 1'b0);
        checkCtrl("sub.fetch_wait0", V_FETCHW);
        nextCycle();
        checkCtrl("sub.fetch_wait1", V_FETCHW);
        fetchDecode("sub", OP_RTYPE, F_SUB, V_DECODE);
        checkCtrl("sub.exec", V_EXEC_SUB);
        nextCycle();
        checkCtrl("sub.aluwb", V_ALUWB);
        nextCycle();
        checkOutput("sub.instret", instret_o, 32'd9);

        fetchDecode("j", OP_J, 6'd0, V_DECODE);
        checkCtrl("j.jump", V_JUMP);
        nextCycle();
        checkOutput("j.instret", instret_o, 32'd10);

        fetchDecode("badop", 6'b111111, 6'd0, V_ILLEGAL);
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkCtrl("badop.refetch", V_FETCH);
        checkOutput("badop.instret", instret_o, 32'd10);

        fetchDecode("badfunct", OP_RTYPE, 6'b111111, V_ILLEGAL);
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkCtrl("badfunct.refetch", V_FETCH);
        checkOutput("badfunct.instret", instret_o, 32'd10);

        fetchDecode("abort", OP_LW, 6'd0, V_DECODE);
        checkCtrl("abort.memadr", V_MEMADR);
        nextCycle();
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
        checkCtrl("abort.memrd", V_MEMRD);
        rst_ni = 1'b0;
        #1;
        checkCtrl("abort.reset_ctrl", V_RESET);
        checkOutput("abort.reset_instret", instret_o, 32'd0);
        nextCycle();
        rst_ni = 1'b1;
        applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
        checkCtrl("abort.refetch", V_FETCH);
        nextCycle();
        checkCtrl("abort.decode", V_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
